// File: rtl/table_fsm_if.sv
// table_fsm_if: run/programming/status bundle for the table-driven state machine.
interface table_fsm_if #(parameter int S_W = 3, parameter int I_W = 1, parameter int O_W = 3);
  logic en;
  logic [I_W-1:0] a;
  logic prog_we;
  logic [S_W+I_W-1:0] prog_addr;
  logic [S_W+O_W-1:0] prog_data;
  logic [S_W+O_W-1:0] prog_rdata;
  logic [S_W-1:0] state;
  logic [O_W-1:0] saida;
  logic err;
  modport master (output en, a, prog_we, prog_addr, prog_data, input prog_rdata, state, saida, err);
  modport slave (input en, a, prog_we, prog_addr, prog_data, output prog_rdata, state, saida, err);
endinterface

// File: rtl/table_fsm.sv
// table_fsm: RAM-programmable state machine indexed by {state, input} with illegal-state trap.
module table_fsm #(
  parameter int S_W = 3,
  parameter int I_W = 1,
  parameter int O_W = 3,
  parameter int NUM_STATES = 5,
  parameter int RESET_STATE = 0,
  parameter int RESET_OUT = 2,
  parameter int LEGACY_INIT = 1
) (
  input logic clk,
  input logic reset,
  table_fsm_if.slave io
);
  localparam int AW = S_W + I_W;
  localparam int DW = S_W + O_W;
  localparam int DEPTH = 2 ** AW;
  localparam logic [7:0] LEGACY [16] = '{
    8'h0E, 8'h0E, 8'h15, 8'h23, 8'h1C, 8'h1C, 8'h02, 8'h0E,
    8'h15, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };
  logic [DW-1:0] tbl [DEPTH];
  logic [DW-1:0] e;
  logic [S_W-1:0] nxt_state;
  logic [O_W-1:0] nxt_saida;
  logic nxt_err;
  logic legal;
  // Entries live outside reset so programmed contents survive it.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [DW-1:0] ent = (LEGACY_INIT != 0 && g < 16) ? DW'(LEGACY[g % 16]) : '0;
    always_ff @(posedge clk)
      if (!reset && io.prog_we && io.prog_addr == AW'(g)) ent <= io.prog_data;
    assign tbl[g] = ent;
  end
  always_comb begin
    e = tbl[{io.state, io.a}];
    legal = 32'(e[DW-1:O_W]) < NUM_STATES;
    nxt_state = io.en ? (legal ? e[DW-1:O_W] : S_W'(RESET_STATE)) : io.state;
    nxt_saida = io.en ? (legal ? e[O_W-1:0] : O_W'(RESET_OUT)) : io.saida;
    nxt_err = io.err | (io.en & ~legal);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      io.state <= S_W'(RESET_STATE);
      io.saida <= O_W'(RESET_OUT);
      io.err <= 1'b0;
      io.prog_rdata <= '0;
    end else begin
      io.state <= nxt_state;
      io.saida <= nxt_saida;
      io.err <= nxt_err;
      io.prog_rdata <= tbl[io.prog_addr];
    end
  end
endmodule
